// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS control unit (states, ALU codes, opcodes, selects).
// Latency: n/a (types, constants and a combinational class decoder only).
// Backpressure: n/a.
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [4:0] {
        ALU_AND = 5'd0, ALU_OR  = 5'd1, ALU_ADD = 5'd2, ALU_SUB = 5'd3, ALU_SLT = 5'd4,
        ALU_NOR = 5'd5, ALU_XOR = 5'd6, ALU_SLL = 5'd7, ALU_SRX = 5'd8, ALU_LUI = 5'd9
    } alu_ctrl_t;

    typedef enum logic [2:0] {ST_IF, ST_ID, ST_EXE, ST_MEM, ST_WB} state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_R_ALU, CLS_I_ALU, CLS_LW, CLS_SW,
        CLS_BEQ, CLS_J, CLS_JAL, CLS_JALR, CLS_JR
    } instr_class_t;

    typedef enum logic [1:0] {SRCA_PC, SRCA_RS, SRCA_SHAMT} src_a_t;
    typedef enum logic [1:0] {SRCB_RT, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} src_b_t;
    typedef enum logic [1:0] {PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_RS} pc_src_t;
    typedef enum logic [1:0] {REGDST_RT, REGDST_RD, REGDST_RA} reg_dst_t;
    typedef enum logic [1:0] {M2R_ALUOUT, M2R_MDR, M2R_PC} mem_to_reg_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

    function automatic instr_class_t decode_class(input logic [5:0] op, input logic [5:0] fn);
        instr_class_t cls;
        cls = CLS_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA: cls = CLS_R_ALU;
                    FN_JR:   cls = CLS_JR;
                    FN_JALR: cls = CLS_JALR;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: cls = CLS_I_ALU;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_op_decode.sv
// Purpose: combinational ALU command decode {state, OpCode, Funct} -> {alu_ctrl, sign, ext_op, lui_op}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows the FSM state.
// Ports: state (current FSM state), op_code/funct (decoded instruction fields),
//        alu_ctrl/sign (ALU command), ext_op (1 = sign-extend imm), lui_op (imm<<16).
module multicycle_ctrl_fsm_alu_op_decode
    import multicycle_ctrl_fsm_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    output logic [4:0] alu_ctrl,
    output logic       sign,
    output logic       ext_op,
    output logic       lui_op
);

    instr_class_t cls;
    assign cls = decode_class(op_code, funct);

    // IF (PC+4) and ID (branch target) both add; only EXE looks at the instruction.
    always_comb begin
        alu_ctrl = ALU_ADD;
        sign     = 1'b0;
        ext_op   = 1'b1;
        lui_op   = 1'b0;
        if (state == ST_EXE) begin
            case (cls)
                CLS_R_ALU: begin
                    case (funct)
                        FN_ADD:  begin alu_ctrl = ALU_ADD; sign = 1'b1; end
                        FN_SUB:  begin alu_ctrl = ALU_SUB; sign = 1'b1; end
                        FN_SUBU: alu_ctrl = ALU_SUB;
                        FN_AND:  alu_ctrl = ALU_AND;
                        FN_OR:   alu_ctrl = ALU_OR;
                        FN_XOR:  alu_ctrl = ALU_XOR;
                        FN_NOR:  alu_ctrl = ALU_NOR;
                        FN_SLT:  begin alu_ctrl = ALU_SLT; sign = 1'b1; end
                        FN_SLTU: alu_ctrl = ALU_SLT;
                        FN_SLL:  alu_ctrl = ALU_SLL;
                        FN_SRL:  alu_ctrl = ALU_SRX;
                        // sra and srl share the shifter; sign selects arithmetic fill
                        FN_SRA:  begin alu_ctrl = ALU_SRX; sign = 1'b1; end
                        default: alu_ctrl = ALU_ADD;
                    endcase
                end
                CLS_I_ALU: begin
                    case (op_code)
                        OP_ADDI: begin alu_ctrl = ALU_ADD; sign = 1'b1; end
                        OP_ANDI: begin alu_ctrl = ALU_AND; ext_op = 1'b0; end
                        OP_ORI:  begin alu_ctrl = ALU_OR;  ext_op = 1'b0; end
                        OP_SLTI: begin alu_ctrl = ALU_SLT; sign = 1'b1; end
                        OP_SLTIU: alu_ctrl = ALU_SLT;
                        OP_LUI:  begin alu_ctrl = ALU_LUI; lui_op = 1'b1; end
                        default: alu_ctrl = ALU_ADD;
                    endcase
                end
                CLS_BEQ: alu_ctrl = ALU_SUB;
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Purpose: multi-cycle MIPS control FSM (IF->ID->EXE->MEM->WB) driving datapath enables and ALU command.
// Latency: 3..5 cycles per instruction plus one per mem_ready-low cycle in IF/MEM.
// Backpressure: holds IF and MEM while mem_ready=0; no other stalls.
// Ports: clk/reset (async active-low); OpCode/Funct from IR; Zero (qualified in the datapath);
//        mem_ready; PC/memory/IR/regfile enables; mux selects; ALUCtrl/Sign/ExtOp/LuiOp; illegal.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int CTRL_W = 5,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   OpCode,
    input  logic [OP_W-1:0]   Funct,
    input  logic              Zero,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              PCWriteCond,
    output logic              IorD,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic [1:0]        RegDst,
    output logic [1:0]        MemtoReg,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic              ExtOp,
    output logic              LuiOp,
    output logic [1:0]        PCSource,
    output logic [CTRL_W-1:0] ALUCtrl,
    output logic              Sign,
    output logic              illegal
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, funct_q;
    logic [OP_W-1:0] dec_op, dec_funct;
    instr_class_t    cls;
    logic [4:0]      alu_ctrl;
    logic            alu_sign, ext_op, lui_op;

    // beq is committed by the datapath ANDing PCWriteCond with Zero; the FSM stays Moore.
    logic unused_zero;
    assign unused_zero = Zero;

    // IR is valid from ID onward; capture it there so later states do not depend on the IR holding.
    assign dec_op    = (state_q == ST_ID) ? OpCode : op_q;
    assign dec_funct = (state_q == ST_ID) ? Funct  : funct_q;
    assign cls       = decode_class(dec_op, dec_funct);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IF;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ID) begin
                op_q    <= OpCode;
                funct_q <= Funct;
            end
        end
    end

    always_comb begin
        state_d = ST_IF;
        case (state_q)
            ST_IF:  state_d = mem_ready ? ST_ID : ST_IF;
            ST_ID:  state_d = (cls == CLS_ILLEGAL) ? ST_IF : ST_EXE;
            ST_EXE: begin
                case (cls)
                    CLS_R_ALU, CLS_I_ALU, CLS_JAL, CLS_JALR: state_d = ST_WB;
                    CLS_LW, CLS_SW:                          state_d = ST_MEM;
                    default:                                 state_d = ST_IF;
                endcase
            end
            ST_MEM: state_d = !mem_ready ? ST_MEM : ((cls == CLS_LW) ? ST_WB : ST_IF);
            default: state_d = ST_IF;
        endcase
    end

    multicycle_ctrl_fsm_alu_op_decode u_alu_op_decode (
        .state    (state_q),
        .op_code  (dec_op),
        .funct    (dec_funct),
        .alu_ctrl (alu_ctrl),
        .sign     (alu_sign),
        .ext_op   (ext_op),
        .lui_op   (lui_op)
    );

    // Everything is forced to zero while reset is low, including the same cycle it drops.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = REGDST_RT;
        MemtoReg    = M2R_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RT;
        PCSource    = PCSRC_ALU;
        illegal     = 1'b0;
        ExtOp       = 1'b0;
        LuiOp       = 1'b0;
        Sign        = 1'b0;
        ALUCtrl     = '0;
        if (reset) begin
            ExtOp   = ext_op;
            LuiOp   = lui_op;
            Sign    = alu_sign;
            ALUCtrl = CTRL_W'(alu_ctrl);
            case (state_q)
                ST_IF: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                ST_ID: begin
                    ALUSrcB = SRCB_IMM_SH2;
                    illegal = (cls == CLS_ILLEGAL);
                end
                ST_EXE: begin
                    case (cls)
                        CLS_R_ALU: ALUSrcA = is_shift(dec_funct) ? SRCA_SHAMT : SRCA_RS;
                        CLS_I_ALU, CLS_LW, CLS_SW: begin
                            ALUSrcA = SRCA_RS;
                            ALUSrcB = SRCB_IMM;
                        end
                        CLS_BEQ: begin
                            ALUSrcA     = SRCA_RS;
                            PCWriteCond = 1'b1;
                            PCSource    = PCSRC_ALUOUT;
                        end
                        CLS_J, CLS_JAL: begin
                            PCWrite  = 1'b1;
                            PCSource = PCSRC_JUMP;
                        end
                        CLS_JALR, CLS_JR: begin
                            PCWrite  = 1'b1;
                            PCSource = PCSRC_RS;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    IorD     = 1'b1;
                    MemRead  = (cls == CLS_LW);
                    MemWrite = (cls == CLS_SW);
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    case (cls)
                        CLS_R_ALU: RegDst = REGDST_RD;
                        CLS_LW:    MemtoReg = M2R_MDR;
                        CLS_JAL:   begin RegDst = REGDST_RA; MemtoReg = M2R_PC; end
                        CLS_JALR:  begin RegDst = REGDST_RD; MemtoReg = M2R_PC; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Purpose: self-checking bench for multicycle_ctrl_fsm against an instruction-table reference.
// Latency: n/a (testbench).
// Backpressure: randomised mem_ready stalls in IF and MEM.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] OpCode = '0, Funct = '0;
    logic       Zero = 1'b0, mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic       ExtOp, LuiOp, Sign, illegal;
    logic [4:0] ALUCtrl;

    multicycle_ctrl_fsm #(.CTRL_W(5), .OP_W(6)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtOp(ExtOp), .LuiOp(LuiOp), .PCSource(PCSource), .ALUCtrl(ALUCtrl), .Sign(Sign),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // One row per instruction: fields in EXE, memory access kind, write-back selects.
    // -1 means the behaviour is not defined for that instruction and is not compared.
    // fn = -1 means Funct is a don't-care and is driven randomly.
    typedef struct packed {
        int op; int fn; int alu; int sgn; int sa; int sb; int ext; int lui;
        int pcw; int pcwc; int pcs; int mem; int wb; int rd; int m2r; int ill;
    } ins_t;

    ins_t  tbl[$];
    string tnm[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic void add(string nm, int op, int fn, int alu, int sgn, int sa, int sb,
                                int ext, int lui, int pcw, int pcwc, int pcs, int mem, int wb,
                                int rd, int m2r, int ill);
        ins_t t;
        t = '{op, fn, alu, sgn, sa, sb, ext, lui, pcw, pcwc, pcs, mem, wb, rd, m2r, ill};
        tbl.push_back(t);
        tnm.push_back(nm);
    endfunction

    function automatic int find(string nm);
        foreach (tnm[i]) if (tnm[i] == nm) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_en(input string p, input int pcw, input int pcwc, input int mr,
                          input int mw, input int irw, input int rw, input int ill);
        chk({p, ".PCWrite"},     32'(PCWrite),     32'(pcw));
        chk({p, ".PCWriteCond"}, 32'(PCWriteCond), 32'(pcwc));
        chk({p, ".MemRead"},     32'(MemRead),     32'(mr));
        chk({p, ".MemWrite"},    32'(MemWrite),    32'(mw));
        chk({p, ".IRWrite"},     32'(IRWrite),     32'(irw));
        chk({p, ".RegWrite"},    32'(RegWrite),    32'(rw));
        chk({p, ".illegal"},     32'(illegal),     32'(ill));
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Called 1-2 time units after a rising edge with the FSM in IF; walks one instruction
    // through every expected cycle and leaves the FSM at the start of the next IF.
    task automatic run_instr(input int k, input int stall_if, input int stall_mem);
        ins_t  t;
        string nm;
        t  = tbl[k];
        nm = tnm[k];
        OpCode = 6'(t.op);
        Funct  = (t.fn < 0) ? 6'($urandom_range(0, 63)) : 6'(t.fn);
        Zero   = (t.pcwc != 0) ? 1'b1 : 1'($urandom_range(0, 1));
        for (int s = 0; s <= stall_if; s++) begin
            mem_ready = (s == stall_if);
            #2;
            chk_en({nm, ".if"}, int'(s == stall_if), 0, 1, 0, int'(s == stall_if), 0, 0);
            chk({nm, ".if.IorD"},     32'(IorD),     0);
            chk({nm, ".if.ALUSrcA"},  32'(ALUSrcA),  0);
            chk({nm, ".if.ALUSrcB"},  32'(ALUSrcB),  1);
            chk({nm, ".if.ALUCtrl"},  32'(ALUCtrl),  2);
            chk({nm, ".if.PCSource"}, 32'(PCSource), 0);
            next_cyc();
        end
        mem_ready = 1'($urandom_range(0, 1));
        #2;
        chk_en({nm, ".id"}, 0, 0, 0, 0, 0, 0, t.ill);
        chk({nm, ".id.ALUSrcA"}, 32'(ALUSrcA), 0);
        chk({nm, ".id.ALUSrcB"}, 32'(ALUSrcB), 3);
        chk({nm, ".id.ExtOp"},   32'(ExtOp),   1);
        chk({nm, ".id.ALUCtrl"}, 32'(ALUCtrl), 2);
        next_cyc();
        if (t.ill != 0) return;
        mem_ready = 1'($urandom_range(0, 1));
        #2;
        chk_en({nm, ".exe"}, t.pcw, t.pcwc, 0, 0, 0, 0, 0);
        chk({nm, ".exe.LuiOp"}, 32'(LuiOp), 32'(t.lui));
        if (t.alu >= 0) begin
            chk({nm, ".exe.ALUCtrl"}, 32'(ALUCtrl), 32'(t.alu));
            chk({nm, ".exe.Sign"},    32'(Sign),    32'(t.sgn));
            chk({nm, ".exe.ALUSrcA"}, 32'(ALUSrcA), 32'(t.sa));
            chk({nm, ".exe.ALUSrcB"}, 32'(ALUSrcB), 32'(t.sb));
        end
        if (t.ext >= 0) chk({nm, ".exe.ExtOp"}, 32'(ExtOp), 32'(t.ext));
        if (t.pcw != 0 || t.pcwc != 0) chk({nm, ".exe.PCSource"}, 32'(PCSource), 32'(t.pcs));
        next_cyc();
        if (t.mem != 0) begin
            for (int s = 0; s <= stall_mem; s++) begin
                mem_ready = (s == stall_mem);
                #2;
                chk_en({nm, ".mem"}, 0, 0, int'(t.mem == 1), int'(t.mem == 2), 0, 0, 0);
                chk({nm, ".mem.IorD"}, 32'(IorD), 1);
                next_cyc();
            end
        end
        if (t.wb != 0) begin
            mem_ready = 1'($urandom_range(0, 1));
            #2;
            chk_en({nm, ".wb"}, 0, 0, 0, 0, 0, 1, 0);
            chk({nm, ".wb.RegDst"},   32'(RegDst),   32'(t.rd));
            chk({nm, ".wb.MemtoReg"}, 32'(MemtoReg), 32'(t.m2r));
            next_cyc();
        end
    endtask

    // Counts cycles from the start of IF until the DUT is back in IF (memory read at the PC),
    // inserting the requested mem_ready-low cycles while the DUT addresses data memory.
    task automatic measure_cpi(input string nm, input int stall_mem, input int exp);
        int k, n, rem;
        bit done;
        k = find(nm);
        n = 0; rem = stall_mem; done = 0;
        OpCode = 6'(tbl[k].op);
        Funct  = 6'(tbl[k].fn);
        Zero   = 1'b1;
        while (!done && n < 20) begin
            #1;
            if (IorD && rem > 0) begin
                mem_ready = 1'b0;
                rem--;
            end else begin
                mem_ready = 1'b1;
            end
            next_cyc();
            n++;
            #1;
            if (MemRead && !IorD) done = 1;
        end
        chk({nm, ".cpi"}, 32'(n), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //  nm       op  fn   alu sg sa sb ext lui pcw pcwc pcs mem wb rd m2r ill
        add("add",   0, 32,   2, 1, 1, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("addu",  0, 33,   2, 0, 1, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("sub",   0, 34,   3, 1, 1, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("subu",  0, 35,   3, 0, 1, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("and",   0, 36,   0, 0, 1, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("or",    0, 37,   1, 0, 1, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("xor",   0, 38,   6, 0, 1, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("nor",   0, 39,   5, 0, 1, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("slt",   0, 42,   4, 1, 1, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("sltu",  0, 43,   4, 0, 1, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("sll",   0,  0,   7, 0, 2, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("srl",   0,  2,   8, 0, 2, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("sra",   0,  3,   8, 1, 2, 0, -1, 0,  0, 0, 0,  0, 1, 1, 0, 0);
        add("jr",    0,  8,  -1, 0, 0, 0, -1, 0,  1, 0, 3,  0, 0, 0, 0, 0);
        add("jalr",  0,  9,  -1, 0, 0, 0, -1, 0,  1, 0, 3,  0, 1, 1, 2, 0);
        add("addi",  8, -1,   2, 1, 1, 2,  1, 0,  0, 0, 0,  0, 1, 0, 0, 0);
        add("addiu", 9, -1,   2, 0, 1, 2,  1, 0,  0, 0, 0,  0, 1, 0, 0, 0);
        add("andi", 12, -1,   0, 0, 1, 2,  0, 0,  0, 0, 0,  0, 1, 0, 0, 0);
        add("ori",  13, -1,   1, 0, 1, 2,  0, 0,  0, 0, 0,  0, 1, 0, 0, 0);
        add("slti", 10, -1,   4, 1, 1, 2,  1, 0,  0, 0, 0,  0, 1, 0, 0, 0);
        add("sltiu",11, -1,   4, 0, 1, 2,  1, 0,  0, 0, 0,  0, 1, 0, 0, 0);
        add("lui",  15, -1,   9, 0, 1, 2, -1, 1,  0, 0, 0,  0, 1, 0, 0, 0);
        add("lw",   35, -1,   2, 0, 1, 2,  1, 0,  0, 0, 0,  1, 1, 0, 1, 0);
        add("sw",   43, -1,   2, 0, 1, 2,  1, 0,  0, 0, 0,  2, 0, 0, 0, 0);
        add("beq",   4, -1,   3, 0, 1, 0, -1, 0,  0, 1, 1,  0, 0, 0, 0, 0);
        add("j",     2, -1,  -1, 0, 0, 0, -1, 0,  1, 0, 2,  0, 0, 0, 0, 0);
        add("jal",   3, -1,  -1, 0, 0, 0, -1, 0,  1, 0, 2,  0, 1, 2, 2, 0);
        add("ill3f",63, -1,  -1, 0, 0, 0, -1, 0,  0, 0, 0,  0, 0, 0, 0, 1);
        add("illfn", 0, 63,  -1, 0, 0, 0, -1, 0,  0, 0, 0,  0, 0, 0, 0, 1);
        add("ill01", 0,  1,  -1, 0, 0, 0, -1, 0,  0, 0, 0,  0, 0, 0, 0, 1);
        add("ill0e",14, -1,  -1, 0, 0, 0, -1, 0,  0, 0, 0,  0, 0, 0, 0, 1);

        // Reset held low with mem_ready high: everything must stay quiet.
        mem_ready = 1'b1;
        OpCode    = 6'h23;
        #12;
        chk_en("rst", 0, 0, 0, 0, 0, 0, 0);
        chk("rst.ALUSrcB", 32'(ALUSrcB), 0);
        chk("rst.ALUCtrl", 32'(ALUCtrl), 0);
        next_cyc();
        reset = 1'b1;
        #1;
        chk("rel.MemRead", 32'(MemRead), 1);
        chk("rel.ALUSrcB", 32'(ALUSrcB), 1);

        run_instr(find("add"),  0, 0);
        run_instr(find("sra"),  1, 0);
        run_instr(find("srl"),  0, 0);
        run_instr(find("lw"),   0, 2);
        run_instr(find("beq"),  0, 0);
        run_instr(find("ill3f"),0, 0);
        run_instr(find("sw"),   2, 1);
        run_instr(find("jal"),  0, 0);

        measure_cpi("add",  0, 4);
        measure_cpi("lw",   2, 7);
        measure_cpi("beq",  0, 3);
        measure_cpi("jr",   0, 3);
        measure_cpi("sw",   0, 4);
        measure_cpi("jalr", 0, 4);

        // Reset dropped in the middle of an add's EXE cycle.
        OpCode = 6'h00; Funct = 6'h20; mem_ready = 1'b1;
        next_cyc();
        next_cyc();
        #1;
        reset = 1'b0;
        #1;
        chk_en("midrst", 0, 0, 0, 0, 0, 0, 0);
        chk("midrst.ALUCtrl", 32'(ALUCtrl), 0);
        chk("midrst.ALUSrcA", 32'(ALUSrcA), 0);
        next_cyc();
        chk("midrst.hold.RegWrite", 32'(RegWrite), 0);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst.rel.MemRead",  32'(MemRead),  1);
        chk("midrst.rel.ALUSrcB",  32'(ALUSrcB),  1);
        chk("midrst.rel.RegWrite", 32'(RegWrite), 0);

        for (int i = 0; i < 300; i++) begin
            run_instr($urandom_range(0, tbl.size() - 1),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
